// File: rtl/sram_port_arbiter_if.sv
// Bundle of the write, read-request, read-response and SRAM array port signals
// shared between sram_port_arbiter (slave side) and its requesters/array (master side).
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [ADDR_W-1:0] rd_req_addr;

  logic              rd_resp_valid;
  logic              rd_resp_ready;
  logic [DATA_W-1:0] rd_resp_data;

  logic              sram_en;
  logic              sram_wmode;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  modport slave (
    input  wr_valid, wr_addr, wr_data,
    input  rd_req_valid, rd_req_addr,
    input  rd_resp_ready,
    input  sram_rdata,
    output wr_ready, rd_req_ready,
    output rd_resp_valid, rd_resp_data,
    output sram_en, sram_wmode, sram_addr, sram_wdata
  );

  modport master (
    output wr_valid, wr_addr, wr_data,
    output rd_req_valid, rd_req_addr,
    output rd_resp_ready,
    output sram_rdata,
    input  wr_ready, rd_req_ready,
    input  rd_resp_valid, rd_resp_data,
    input  sram_en, sram_wmode, sram_addr, sram_wdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Single-port SRAM front end: merges write and read-request channels onto the array port
// and buffers read data in a response FIFO. Define SRAM_ARB_RR_EN for round-robin conflicts.
module sram_port_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 16,
  parameter int RESP_DEPTH = 3
) (
  input  logic            clock,
  input  logic            reset_n,
  sram_port_arbiter_if.slave bus
);

  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int OCC_W = $clog2(RESP_DEPTH + 1);

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [OCC_W-1:0]  occ;
  logic              inflight;
  logic [DATA_W-1:0] fifo_mem [RESP_DEPTH];

  logic [OCC_W:0]    reserved;
  logic              rd_ok;
  logic              wr_elig;
  logic              rd_elig;
  logic              grant_wr;
  logic              grant_rd;
  logic              push;
  logic              pop;
  logic              resp_valid;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Slots already spoken for: stored entries plus the read whose data arrives this cycle.
  assign reserved = {1'b0, occ} + (OCC_W + 1)'(inflight);
  assign rd_ok    = reserved < (OCC_W + 1)'(RESP_DEPTH);

  assign wr_elig  = reset_n && bus.wr_valid;
  assign rd_elig  = reset_n && bus.rd_req_valid && rd_ok;

`ifdef SRAM_ARB_RR_EN
  logic rr_favor_rd;
  logic conflict;

  assign conflict = wr_elig && rd_elig;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_favor_rd <= 1'b0;
    end else if (conflict) begin
      rr_favor_rd <= !rr_favor_rd;
    end
  end

  assign grant_wr = wr_elig && !(rd_elig && rr_favor_rd);
`else
  assign grant_wr = wr_elig;
`endif
  assign grant_rd = rd_elig && !grant_wr;

  assign bus.wr_ready     = grant_wr;
  assign bus.rd_req_ready = grant_rd;

  always_comb begin
    bus.sram_en    = 1'b0;
    bus.sram_wmode = 1'b0;
    bus.sram_addr  = '0;
    bus.sram_wdata = '0;
    if (grant_wr) begin
      bus.sram_en    = 1'b1;
      bus.sram_wmode = 1'b1;
      bus.sram_addr  = bus.wr_addr;
      bus.sram_wdata = bus.wr_data;
    end else if (grant_rd) begin
      bus.sram_en    = 1'b1;
      bus.sram_addr  = bus.rd_req_addr;
    end
  end

  assign push       = inflight;
  assign resp_valid = (occ != '0);
  assign pop        = resp_valid && bus.rd_resp_ready;

  assign bus.rd_resp_valid = resp_valid;
  // Masked while empty so stale entries never appear on the response bus.
  assign bus.rd_resp_data  = resp_valid ? fifo_mem[rd_ptr] : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= grant_rd;
      if (push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      if (push && !pop) begin
        occ <= occ + OCC_W'(1);
      end else if (pop && !push) begin
        occ <= occ - OCC_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= bus.sram_rdata;
    end
  end

endmodule
